vga_fb_arbiter: RTL
===================

// Module: vga_fb_arbiter
// PURPOSE
//  Owns the single-port framebuffer RAM shared by the UART image writer and the VGA pixel output stage.
//  Issues one read per displayed pixel, timed so that rgb_colour holds the correct pixel on the next enable.
//  Grants UART writes into all remaining RAM cycles and sequences the write address.
//  Sits between the UART pixel assembler, the pixel RAM and vga_send_image; the timing counters drive h_count/v_count/enable.
// PARAMETERS
//  ACTIVE_HORI 640   visible pixels per line
//  H_TOTAL     800   total clocks-of-enable per line (active + porches + sync)
//  ACTIVE_VERT 480   visible lines
//  V_TOTAL     525   total lines per frame
//  SCALE_SHIFT 2     log2 of the upscale factor; FB is (ACTIVE_HORI>>S) x (ACTIVE_VERT>>S)
//  FB_WIDTH    160   framebuffer columns (= ACTIVE_HORI>>SCALE_SHIFT)
//  FB_HEIGHT   120   framebuffer rows (= ACTIVE_VERT>>SCALE_SHIFT)
//  ADDR_W      15    RAM address width; must satisfy 2**ADDR_W >= FB_WIDTH*FB_HEIGHT
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  enable      in   1       pixel tick; vga_send_image samples rgb_colour on this cycle
//  h_count     in   10      current horizontal count (pixel sampled this enable)
//  v_count     in   10      current vertical count
//  wr_valid    in   1       UART pixel available
//  wr_sof      in   1       qualifies wr_valid: this pixel is FB address 0
//  wr_data     in   12      RGB444 pixel {R,G,B}
//  wr_ready    out  1       write accepted this cycle when wr_valid & wr_ready
//  frame_done  out  1       1-cycle pulse: last FB address written
//  mem_addr    out  ADDR_W  RAM address
//  mem_we      out  1       RAM write strobe
//  mem_wdata   out  12      RAM write data
//  mem_rdata   in   12      RAM read data, valid 1 cycle after a read is issued
//  rgb_colour  out  12      pixel to vga_send_image
// BEHAVIOUR
//  Reset: rgb_colour=0, wr_ptr=0, rd_pending=0, frame_done=0; mem_we=0 and wr_ready=0 while reset=1.
//  Next pixel (nh,nv): if h_count==H_TOTAL-1 then nh=0, nv=(v_count==V_TOTAL-1)?0:v_count+1;
//    otherwise nh=h_count+1, nv=v_count. Counts >= totals are treated as non-active; no read is issued.
//  need_rd = enable & (nh<ACTIVE_HORI) & (nv<ACTIVE_VERT).
//  Read slot: when need_rd, mem_addr=(nv>>S)*FB_WIDTH+(nh>>S) and mem_we=0 (combinational this cycle).
//    rd_pending<=1. On the next cycle, rgb_colour<=mem_rdata.
//    Latency: issue on enable N, rgb_colour valid 1 cycle later, stable until sampled at enable N+1.
//  enable & !need_rd: rgb_colour<=0 (blank next pixel); no RAM read.
//  Reads have absolute priority: wr_ready = !reset & !need_rd.
//    Requires enable spacing >= 2 clocks (PERIOD_COUNT >= 2).
//  Write: on wr_valid & wr_ready:
//    mem_we=1, mem_wdata=wr_data, mem_addr = wr_sof ? 0 : wr_ptr.
//    Then wr_ptr <= (used_addr==FB_WIDTH*FB_HEIGHT-1) ? 0 : used_addr+1.
//  frame_done<=1 for one cycle after a write to FB_WIDTH*FB_HEIGHT-1. Wrap continues without stalling.
//  Idle cycles (no read, no write): mem_we=0, mem_addr=wr_ptr, rgb_colour holds.
//  wr_valid held while wr_ready=0: no transfer, wr_ptr holds; data must stay stable (valid/ready rule).
//  Reset mid-frame: state clears on the same edge; the write stream restarts at address 0 with or without sof.
//  Address arithmetic is unsigned at ADDR_W bits. Multiply by the FB_WIDTH constant; no overflow for legal dims.
// STRUCTURE
//  vga_pkg: ACTIVE/TOTAL timing constants, FB_WIDTH/FB_HEIGHT, FB_DEPTH, typedef logic [11:0] rgb444_t.
//  Sub-module vga_fb_addr_gen (comb): h/v -> nh/nv, active flag, FB address. Arbiter and registers stay in top.
// TESTING
//  1. Reset held 3 clks with wr_valid=1 -> wr_ready=0, mem_we=0, rgb_colour=0 throughout.
//  2. enable at h=9,v=5 -> mem_addr=1*160+2=162, we=0; mem_rdata=12'hABC next clk -> rgb_colour=ABC.
//  3. enable at h=799,v=479 -> no read (nv=480 inactive), rgb_colour=0; enable at h=799,v=524 -> read addr 0.
//  4. wr_valid held, enable every 4 clks in active area -> writes on 3 of 4 clks, stall on enable clks, addresses sequential.
//  5. 19200 writes from sof -> frame_done pulses once after address 19199 is written; next write goes to address 0.
//  6. wr_sof mid-stream at wr_ptr=500 -> write to 0, wr_ptr=1; reset at wr_ptr=77 -> next write to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and pixel type for the VGA framebuffer path.
package vga_pkg;

  localparam int unsigned ACTIVE_HORI = 640;
  localparam int unsigned H_TOTAL     = 800;
  localparam int unsigned ACTIVE_VERT = 480;
  localparam int unsigned V_TOTAL     = 525;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned FB_WIDTH    = ACTIVE_HORI >> SCALE_SHIFT;
  localparam int unsigned FB_HEIGHT   = ACTIVE_VERT >> SCALE_SHIFT;
  localparam int unsigned FB_DEPTH    = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned CNT_W       = 10;
  localparam int unsigned RGB_W       = 12;

  typedef logic [RGB_W-1:0] rgb444_t;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Predicts the pixel shown at the next enable and maps it to its framebuffer address.
module vga_fb_addr_gen
  import vga_pkg::*;
(
  input  logic [CNT_W-1:0]  h_count,
  input  logic [CNT_W-1:0]  v_count,
  output logic              active,
  output logic [ADDR_W-1:0] fb_addr
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_TOT  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOT  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(ACTIVE_HORI);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(ACTIVE_VERT);

  logic [CNT_W-1:0] nh;
  logic [CNT_W-1:0] nv;
  logic             in_range;

  // Next-pixel coordinates; out-of-range counts never produce a read even if +1 would wrap.
  always_comb begin
    in_range = (h_count < H_TOT) && (v_count < V_TOT);
    if (h_count == H_LAST) begin
      nh = '0;
      nv = (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      nh = h_count + 1'b1;
      nv = v_count;
    end
    active  = in_range && (nh < H_ACT) && (nv < V_ACT);
    fb_addr = ADDR_W'(nv >> SCALE_SHIFT) * ADDR_W'(FB_WIDTH) + ADDR_W'(nh >> SCALE_SHIFT);
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads take priority, UART writes fill the rest.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  h_count,
  input  logic [CNT_W-1:0]  v_count,
  input  logic              wr_valid,
  input  logic              wr_sof,
  input  rgb444_t           wr_data,
  output logic              wr_ready,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output rgb444_t           mem_wdata,
  input  rgb444_t           mem_rdata,
  output rgb444_t           rgb_colour
);

  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_DEPTH - 1);

  logic              fb_active;
  logic [ADDR_W-1:0] fb_addr;
  logic              need_rd;
  logic              wr_fire;
  logic [ADDR_W-1:0] used_addr;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              rd_pending_q, rd_pending_d;
  rgb444_t           rgb_q, rgb_d;
  logic              frame_done_q, frame_done_d;

  vga_fb_addr_gen u_addr_gen (
    .h_count (h_count),
    .v_count (v_count),
    .active  (fb_active),
    .fb_addr (fb_addr)
  );

  // RAM port arbitration, write-pointer sequencing and pixel capture.
  always_comb begin
    need_rd      = enable & fb_active;
    wr_ready     = ~reset & ~need_rd;
    wr_fire      = wr_valid & wr_ready;
    used_addr    = wr_sof ? '0 : wr_ptr_q;
    mem_we       = 1'b0;
    mem_wdata    = wr_data;
    mem_addr     = wr_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    frame_done_d = 1'b0;
    rd_pending_d = need_rd;
    rgb_d        = rgb_q;

    if (need_rd) begin
      mem_addr = fb_addr;
    end else if (wr_fire) begin
      mem_we       = 1'b1;
      mem_addr     = used_addr;
      wr_ptr_d     = (used_addr == FB_LAST) ? '0 : used_addr + 1'b1;
      frame_done_d = (used_addr == FB_LAST);
    end

    if (rd_pending_q) begin
      rgb_d = mem_rdata;
    end else if (enable && !need_rd) begin
      rgb_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_pending_q <= 1'b0;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_pending_q <= rd_pending_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rgb_colour = rgb_q;
  assign frame_done = frame_done_q;

endmodule
